// File: rtl/jzjpcc_data_memory_backend.sv
// jzjpcc_data_memory_backend
//
// Data-side memory backend for the memory stage. It accepts one request per clock,
// with no handshake and no stall. The request is either a word-addressed RAM access
// or an access to a 32-byte MMIO window. Read data is registered, so it returns one
// cycle after the request.
//
// MMIO window offsets:
//   0x00 PORT_OUT  read/write, byte-masked
//   0x04 PORT_IN   read-only, portIn after a two-flop synchronizer
//   0x08 CYCLE_LO  read-only, low half of the free-running counter; a read also
//                  captures the high half into a shadow register
//   0x0C CYCLE_HI  read-only, the shadow captured by the last CYCLE_LO read
//   0x10-0x1C      unmapped, read as zero, writes ignored
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   memWriteEnable  write strobe
//   memAddress      byte address; bits [1:0] ignored
//   memDataToWrite  lane-aligned write data
//   memByteMask     per-byte write enables
//   memDataRead     registered read data (all four lanes)
//   portOut         PORT_OUT register contents
//   portIn          asynchronous external input word
module jzjpcc_data_memory_backend #(
    parameter int unsigned RAM_WORDS_LOG2 = 10,
    parameter logic [31:0] MMIO_BASE      = 32'hFFFFFFE0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memWriteEnable,
    input  logic [31:0] memAddress,
    input  logic [31:0] memDataToWrite,
    input  logic [3:0]  memByteMask,
    output logic [31:0] memDataRead,
    output logic [31:0] portOut,
    input  logic [31:0] portIn
);

    localparam int unsigned RamWords = 2 ** RAM_WORDS_LOG2;

    localparam logic [2:0] OffPortOut = 3'd0;
    localparam logic [2:0] OffPortIn  = 3'd1;
    localparam logic [2:0] OffCycleLo = 3'd2;
    localparam logic [2:0] OffCycleHi = 3'd3;

    logic [31:0]               ram [RamWords];
    logic                      is_mmio;
    logic [2:0]                mmio_offset;
    logic [RAM_WORDS_LOG2-1:0] ram_index;
    logic                      write_ok;
    logic [31:0]               read_data;
    logic [31:0]               port_out_d;

    logic [31:0] read_q;
    logic [31:0] port_out_q;
    logic [31:0] port_in_meta_q;
    logic [31:0] port_in_sync_q;
    logic [63:0] cycle_q;
    logic [31:0] cycle_hi_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^memAddress[1:0];

    assign is_mmio     = (memAddress[31:5] == MMIO_BASE[31:5]);
    assign mmio_offset = memAddress[4:2];
    assign ram_index   = memAddress[RAM_WORDS_LOG2+1:2];
    // Reset gates every write, including one presented on the edge reset asserts.
    assign write_ok    = memWriteEnable & ~reset;

    // RAM has no reset. The nonblocking update makes a same-word read return the old word.
    always_ff @(posedge clock) begin
        if (write_ok && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (memByteMask[i]) begin
                    ram[ram_index][8*i +: 8] <= memDataToWrite[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        port_out_d = port_out_q;
        for (int i = 0; i < 4; i++) begin
            if (memByteMask[i]) begin
                port_out_d[8*i +: 8] = memDataToWrite[8*i +: 8];
            end
        end
    end

    always_comb begin
        read_data = 32'h0;
        if (is_mmio) begin
            case (mmio_offset)
                OffPortOut: read_data = port_out_q;
                OffPortIn:  read_data = port_in_sync_q;
                OffCycleLo: read_data = cycle_q[31:0];
                OffCycleHi: read_data = cycle_hi_q;
                default:    read_data = 32'h0;
            endcase
        end else begin
            read_data = ram[ram_index];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_q         <= 32'h0;
            port_out_q     <= 32'h0;
            port_in_meta_q <= 32'h0;
            port_in_sync_q <= 32'h0;
            cycle_q        <= 64'h0;
            cycle_hi_q     <= 32'h0;
        end else begin
            read_q         <= read_data;
            port_in_meta_q <= portIn;
            port_in_sync_q <= port_in_meta_q;
            cycle_q        <= cycle_q + 64'd1;
            if (write_ok && is_mmio && mmio_offset == OffPortOut) begin
                port_out_q <= port_out_d;
            end
            // Snapshot the high half with the low half so a LO-then-HI pair is never torn.
            if (is_mmio && mmio_offset == OffCycleLo) begin
                cycle_hi_q <= cycle_q[63:32];
            end
        end
    end

    assign memDataRead = read_q;
    assign portOut     = port_out_q;

endmodule

// File: tb/tb_jzjpcc_data_memory_backend.sv
// Directed testbench for jzjpcc_data_memory_backend.
// Each request is driven just after a rising edge and checked 1 ns after the next edge.
module tb_jzjpcc_data_memory_backend;

    localparam logic [31:0] Base = 32'hFFFFFFE0;

    logic        clock;
    logic        reset;
    logic        memWriteEnable;
    logic [31:0] memAddress;
    logic [31:0] memDataToWrite;
    logic [3:0]  memByteMask;
    logic [31:0] memDataRead;
    logic [31:0] portOut;
    logic [31:0] portIn;

    int n_checks = 0;
    int n_errors = 0;

    // Counter model: the value the DUT counter holds before the next edge.
    logic [63:0] cyc_model = 64'h0;
    logic [63:0] last_cyc  = 64'h0;
    logic [31:0] hi_exp;

    jzjpcc_data_memory_backend #(
        .RAM_WORDS_LOG2(10),
        .MMIO_BASE     (Base)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .memWriteEnable(memWriteEnable),
        .memAddress    (memAddress),
        .memDataToWrite(memDataToWrite),
        .memByteMask   (memByteMask),
        .memDataRead   (memDataRead),
        .portOut       (portOut),
        .portIn        (portIn)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present one request, step across one edge, and settle 1 ns later.
    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask);
        memWriteEnable = we;
        memAddress     = addr;
        memDataToWrite = data;
        memByteMask    = mask;
        last_cyc       = cyc_model;
        @(posedge clock);
        if (reset) cyc_model = 64'h0;
        else       cyc_model = cyc_model + 64'd1;
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        memWriteEnable = 1'b0;
        memAddress     = 32'h0;
        memDataToWrite = 32'h0;
        memByteMask    = 4'h0;
        portIn         = 32'h0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state, with a PORT_OUT write presented while reset is high.
        req(1'b1, Base, 32'h000000FF, 4'hF);
        check("rst_read", memDataRead, 32'h0);
        check("rst_portout", portOut, 32'h0);

        reset = 1'b0;
        check("first_cycle_read", memDataRead, 32'h0);
        req(1'b0, Base + 32'h8, 32'h0, 4'h0);
        check("cnt_first", memDataRead, last_cyc[31:0]);
        check("rst_write_dropped", portOut, 32'h0);
        req(1'b0, Base + 32'h8, 32'h0, 4'h0);
        check("cnt_second", memDataRead, last_cyc[31:0]);

        // Byte-masked RAM write.
        req(1'b1, 32'h100, 32'hAABBCCDD, 4'b1111);
        req(1'b1, 32'h100, 32'h11223344, 4'b0101);
        req(1'b0, 32'h100, 32'h0, 4'h0);
        check("byte_mask", memDataRead, 32'hAA22CC44);

        // Read-first on a same-word write.
        req(1'b1, 32'h100, 32'h12345678, 4'hF);
        req(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
        check("read_first_old", memDataRead, 32'h12345678);
        req(1'b0, 32'h100, 32'h0, 4'h0);
        check("read_first_new", memDataRead, 32'hFFFFFFFF);

        // A zero mask writes nothing.
        req(1'b1, 32'h100, 32'h00000000, 4'h0);
        req(1'b0, 32'h100, 32'h0, 4'h0);
        check("mask_zero", memDataRead, 32'hFFFFFFFF);

        // Aliasing modulo RAM size; MMIO writes stay out of RAM.
        req(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF);
        req(1'b0, 32'h0, 32'h0, 4'h0);
        check("alias", memDataRead, 32'hCAFEF00D);
        req(1'b1, 32'h8, 32'h22222222, 4'hF);
        req(1'b1, 32'hFE8, 32'h33333333, 4'hF);
        req(1'b1, 32'hFF0, 32'h44444444, 4'hF);
        req(1'b1, Base + 32'h8, 32'hDEADBEEF, 4'hF);
        check("cyclo_wr_ignored", memDataRead, last_cyc[31:0]);
        req(1'b1, Base + 32'h10, 32'hDEADBEEF, 4'hF);
        check("unmapped_read", memDataRead, 32'h0);
        req(1'b1, Base + 32'h4, 32'hDEADBEEF, 4'hF);
        check("portin_ro", memDataRead, 32'h0);
        req(1'b0, 32'h8, 32'h0, 4'h0);
        check("ram_idx2_intact", memDataRead, 32'h22222222);
        req(1'b0, 32'hFE8, 32'h0, 4'h0);
        check("ram_fe8_intact", memDataRead, 32'h33333333);
        req(1'b0, 32'hFF0, 32'h0, 4'h0);
        check("ram_ff0_intact", memDataRead, 32'h44444444);
        req(1'b0, Base + 32'h8, 32'h0, 4'h0);
        check("cnt_unchanged", memDataRead, last_cyc[31:0]);

        // PORT_OUT byte-masked writes and readback.
        req(1'b1, Base, 32'h000000A5, 4'b0001);
        check("portout_a5", portOut, 32'h000000A5);
        req(1'b1, Base, 32'h12345600, 4'b1110);
        check("portout_merge", portOut, 32'h123456A5);
        req(1'b0, Base, 32'h0, 4'h0);
        check("portout_read", memDataRead, 32'h123456A5);

        // PORT_IN becomes visible at the third edge after it changes.
        portIn = 32'h0000005A;
        req(1'b0, Base + 32'h4, 32'h0, 4'h0);
        check("portin_e1", memDataRead, 32'h0);
        req(1'b0, Base + 32'h4, 32'h0, 4'h0);
        check("portin_e2", memDataRead, 32'h0);
        req(1'b0, Base + 32'h4, 32'h0, 4'h0);
        check("portin_e3", memDataRead, 32'h0000005A);

        // Counter snapshot across the 32-bit carry.
        force dut.cycle_q = 64'h00000000_FFFFFFFE;
        #1;
        release dut.cycle_q;
        cyc_model = 64'h00000000_FFFFFFFE;
        req(1'b0, 32'h100, 32'h0, 4'h0);
        req(1'b0, Base + 32'h8, 32'h0, 4'h0);
        hi_exp = last_cyc[63:32];
        check("snap_lo", memDataRead, 32'hFFFFFFFF);
        req(1'b0, Base + 32'hC, 32'h0, 4'h0);
        check("snap_hi", memDataRead, hi_exp);
        req(1'b0, Base + 32'h8, 32'h0, 4'h0);
        hi_exp = last_cyc[63:32];
        check("snap_lo2", memDataRead, last_cyc[31:0]);
        req(1'b0, Base + 32'hC, 32'h0, 4'h0);
        check("snap_hi2", memDataRead, hi_exp);

        // Reset mid-operation with PORT_OUT and RAM writes presented.
        reset = 1'b1;
        req(1'b1, Base, 32'h000000FF, 4'hF);
        check("midrst_portout", portOut, 32'h0);
        check("midrst_read", memDataRead, 32'h0);
        req(1'b1, 32'h100, 32'h0BADF00D, 4'hF);
        reset = 1'b0;
        req(1'b0, Base + 32'hC, 32'h0, 4'h0);
        check("midrst_hi_shadow", memDataRead, 32'h0);
        req(1'b0, Base + 32'h8, 32'h0, 4'h0);
        check("midrst_cnt", memDataRead, last_cyc[31:0]);
        req(1'b0, Base, 32'h0, 4'h0);
        check("midrst_portout_rd", memDataRead, 32'h0);
        req(1'b0, 32'h100, 32'h0, 4'h0);
        check("midrst_ram_dropped", memDataRead, 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
